// File: rtl/module_result_bcd.sv
// Captures a divider quotient/remainder pair and converts both to 3-digit packed BCD
// with a sequential double-dabble engine. Optional feature macro: RESULT_ERRCODE_EN.
module module_result_bcd #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic             i_error,
  input  logic [WIDTH-1:0] i_quotient,
  input  logic [WIDTH-1:0] i_remainder,
  output logic [11:0]      o_q_bcd,
  output logic [11:0]      o_r_bcd,
  output logic             o_valid,
  output logic             o_error,
  output logic             o_busy
);

  localparam int unsigned SrW = 12 + WIDTH;

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e           state_q, state_d;
  logic [SrW-1:0]   q_sr_q, q_sr_d;
  logic [SrW-1:0]   r_sr_q, r_sr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [11:0]      q_bcd_q, q_bcd_d;
  logic [11:0]      r_bcd_q, r_bcd_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;

  // Add 3 to every nibble >= 5 ahead of the shift so digits carry correctly.
  function automatic logic [11:0] dabble_adj(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [SrW-1:0] dabble_step(input logic [SrW-1:0] sr);
    logic [SrW-1:0] t;
    t = {dabble_adj(sr[SrW-1 -: 12]), sr[WIDTH-1:0]};
    return {t[SrW-2:0], 1'b0};
  endfunction

  always_comb begin
    state_d = state_q;
    q_sr_d  = q_sr_q;
    r_sr_d  = r_sr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    q_bcd_d = q_bcd_q;
    r_bcd_d = r_bcd_q;
    valid_d = 1'b0;
    error_d = error_q;
    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          q_sr_d  = {12'h000, i_quotient};
          r_sr_d  = {12'h000, i_remainder};
          cnt_d   = 4'(WIDTH);
          err_d   = i_error;
`ifdef RESULT_ERRCODE_EN
          state_d = i_error ? StDone : StConv;
`else
          state_d = StConv;
`endif
        end
      end
      StConv: begin
        q_sr_d = dabble_step(q_sr_q);
        r_sr_d = dabble_step(r_sr_q);
        cnt_d  = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StDone;
      end
      StDone: begin
        q_bcd_d = q_sr_q[SrW-1 -: 12];
        r_bcd_d = r_sr_q[SrW-1 -: 12];
`ifdef RESULT_ERRCODE_EN
        if (err_q) begin
          q_bcd_d = 12'hEEE;
          r_bcd_d = 12'hEEE;
        end
`endif
        error_d = err_q;
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      q_sr_q  <= '0;
      r_sr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      q_bcd_q <= '0;
      r_bcd_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      q_sr_q  <= q_sr_d;
      r_sr_q  <= r_sr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      q_bcd_q <= q_bcd_d;
      r_bcd_q <= r_bcd_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  assign o_q_bcd = q_bcd_q;
  assign o_r_bcd = r_bcd_q;
  assign o_valid = valid_q;
  assign o_error = error_q;
  assign o_busy  = (state_q != StIdle);

endmodule
